// File: rtl/rf_pkg.sv
// Shared definitions for the 2-read / 1-write register file.
//
// Contents:
//   RF_DATA_WIDTH  default register / data-port width
//   RF_ADDR_WIDTH  default address-port width
//   RF_DEPTH       default number of registers (2**RF_ADDR_WIDTH)
//   RF_ZERO_ADDR   address of the optionally hardwired zero register
//   rf_data_t      one register word
//   rf_addr_t      one register address
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DEPTH      = 32;
    localparam int RF_ZERO_ADDR  = 0;

    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;
    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// Combinational read path for one port of the register file.
//
// Selects one of DEPTH registers with a binary mux tree, then applies the
// write-first bypass (a same-edge write to the addressed register wins) and
// the optional zero-register override. Output registering lives in the top.
//
// Ports:
//   rd_addr  in   ADDR_WIDTH            address for this port
//   wr_en    in   1                     write request on this edge
//   wr_addr  in   ADDR_WIDTH            write address
//   wr_data  in   DATA_WIDTH            write data
//   mem      in   DEPTH x DATA_WIDTH    current register contents
//   rd_data  out  DATA_WIDTH            value to capture into the read register
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DEPTH      = RF_DEPTH,
    parameter int ZERO_REG   = 1
) (
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem,
    output logic [DATA_WIDTH-1:0]             rd_data
);

    // Heap-ordered mux tree: node 0 is the root, node k has children 2k+1 and
    // 2k+2, and the DEPTH leaves sit at DEPTH-1 .. 2*DEPTH-2 in address order.
    // A node at tree level L steers on address bit ADDR_WIDTH-1-L, so the
    // root uses the MSB and the last internal level uses the LSB.
    localparam int NODES = 2 * DEPTH - 1;

    logic [DATA_WIDTH-1:0] node [NODES];

    for (genvar i = 0; i < DEPTH; i++) begin : g_leaf
        assign node[DEPTH-1+i] = mem[i];
    end

    for (genvar k = 0; k < DEPTH - 1; k++) begin : g_node
        localparam int LEVEL = $clog2(k + 2) - 1;
        assign node[k] = rd_addr[ADDR_WIDTH-1-LEVEL] ? node[2*k+2] : node[2*k+1];
    end

    logic zero_hit;
    logic bypass_hit;

    assign zero_hit   = (ZERO_REG != 0) && (rd_addr == ADDR_WIDTH'(RF_ZERO_ADDR));
    assign bypass_hit = wr_en && (wr_addr == rd_addr);

    always_comb begin
        // NOTE: rd_data gets a value before any branch so no path through the
        // block leaves it unassigned; that is what keeps a latch from forming.
        rd_data = node[0];
        if (zero_hit) begin
            rd_data = '0;
        end else if (bypass_hit) begin
            rd_data = wr_data;
        end
    end

endmodule : rf_read_port

// File: rtl/reg_file_2r1w.sv
// Register file: DEPTH registers of DATA_WIDTH bits, two registered read
// ports and one write port, with a one-cycle VALID strobe per accepted read.
// Reads see same-edge writes (write-first). With ZERO_REG=1, register 0
// reads as zero and discards writes.
//
// Ports:
//   CLK      in   1           clock, rising edge
//   RST      in   1           synchronous active-high reset
//   READ     in   1           read request
//   WRITE    in   1           write request
//   ADDR_R1  in   ADDR_WIDTH  read port 1 address
//   ADDR_R2  in   ADDR_WIDTH  read port 2 address
//   ADDR_W   in   ADDR_WIDTH  write address
//   DATA_W   in   DATA_WIDTH  write data
//   DATA_R1  out  DATA_WIDTH  registered read data, port 1
//   DATA_R2  out  DATA_WIDTH  registered read data, port 2
//   VALID    out  1           one-cycle strobe after each accepted read
module reg_file_2r1w
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DEPTH      = RF_DEPTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  VALID
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [DATA_WIDTH-1:0]            rd1_next;
    logic [DATA_WIDTH-1:0]            rd2_next;
    logic                             wr_commit;

    // A write to the zero register is dropped here, so mem[0] stays at its
    // reset value of zero for the life of the design.
    assign wr_commit = WRITE &&
                       !((ZERO_REG != 0) && (ADDR_W == ADDR_WIDTH'(RF_ZERO_ADDR)));

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .ZERO_REG   (ZERO_REG)
    ) u_read_port_1 (
        .rd_addr (ADDR_R1),
        .wr_en   (WRITE),
        .wr_addr (ADDR_W),
        .wr_data (DATA_W),
        .mem     (mem),
        .rd_data (rd1_next)
    );

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .ZERO_REG   (ZERO_REG)
    ) u_read_port_2 (
        .rd_addr (ADDR_R2),
        .wr_en   (WRITE),
        .wr_addr (ADDR_W),
        .wr_data (DATA_W),
        .mem     (mem),
        .rd_data (rd2_next)
    );

    // NOTE: the register array is built from flip-flops and cleared by
    // reset, so it cannot map onto a RAM macro; the clear-on-reset contract
    // of this block depends on that.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem <= '0;
        end else if (wr_commit) begin
            mem[ADDR_W] <= DATA_W;
        end
    end

    // Read data registers hold their value while READ is low; only VALID
    // follows READ every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values, independent of statement order.
            DATA_R1 <= '0;
            DATA_R2 <= '0;
            VALID   <= 1'b0;
        end else begin
            VALID <= READ;
            if (READ) begin
                DATA_R1 <= rd1_next;
                DATA_R2 <= rd2_next;
            end
        end
    end

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w. Each issued read pushes its
// expected pair into a queue; a monitor pops and compares on every VALID.
module tb_reg_file_2r1w;
    import rf_pkg::*;

    typedef struct packed {
        rf_data_t d1;
        rf_data_t d2;
    } rd_pair_t;

    logic     CLK;
    logic     RST;
    logic     READ;
    logic     WRITE;
    rf_addr_t ADDR_R1;
    rf_addr_t ADDR_R2;
    rf_addr_t ADDR_W;
    rf_data_t DATA_W;
    rf_data_t DATA_R1;
    rf_data_t DATA_R2;
    logic     VALID;

    rd_pair_t exp_q[$];
    int       n_cmp = 0;
    int       n_err = 0;
    bit       mon_en = 1'b0;

    reg_file_2r1w #(
        .DATA_WIDTH (RF_DATA_WIDTH),
        .ADDR_WIDTH (RF_ADDR_WIDTH),
        .DEPTH      (RF_DEPTH),
        .ZERO_REG   (1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .READ    (READ),
        .WRITE   (WRITE),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2),
        .VALID   (VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: outputs change only at posedge, so sample at negedge.
    always @(negedge CLK) begin
        if (mon_en && VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got VALID=1 with no read outstanding");
            end else begin
                rd_pair_t e;
                e = exp_q.pop_front();
                check("rd_port1", DATA_R1, e.d1);
                check("rd_port2", DATA_R2, e.d2);
            end
        end
    end

    // Inputs change 1 time unit after the edge; checks taken there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input int a1, input int a2,
                         input int aw, input logic [31:0] dw);
        READ    = rd;
        WRITE   = wr;
        ADDR_R1 = rf_addr_t'(a1);
        ADDR_R2 = rf_addr_t'(a2);
        ADDR_W  = rf_addr_t'(aw);
        DATA_W  = dw;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 0, 32'h0);
    endtask

    task automatic wr(input int aw, input logic [31:0] dw);
        drive(1'b0, 1'b1, 0, 0, aw, dw);
        tick();
    endtask

    task automatic rd(input int a1, input int a2, input logic [31:0] e1, input logic [31:0] e2);
        drive(1'b1, 1'b0, a1, a2, 0, 32'h0);
        exp_q.push_back('{d1: e1, d2: e2});
        tick();
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        idle();
        RST = 1'b1;
        tick();
        tick();
        check("reset_valid", {31'b0, VALID}, 32'h0);
        check("reset_r1", DATA_R1, 32'h0);
        check("reset_r2", DATA_R2, 32'h0);
        RST    = 1'b0;
        mon_en = 1'b1;

        // Freshly reset registers read as zero; VALID is a single pulse.
        rd(5, 31, 32'h0, 32'h0);
        check("valid_pulse_hi", {31'b0, VALID}, 32'h1);
        idle();
        tick();
        check("valid_pulse_lo", {31'b0, VALID}, 32'h0);

        // Write then read.
        wr(7, 32'hDEADBEEF);
        wr(15, 32'h00000010);
        rd(7, 15, 32'hDEADBEEF, 32'h00000010);

        // Zero register: write dropped, same-edge bypass suppressed.
        wr(0, 32'hFFFFFFFF);
        rd(0, 0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 0, 0, 0, 32'hFFFFFFFF);
        exp_q.push_back('{d1: 32'h0, d2: 32'h0});
        tick();

        // Write-first bypass on both ports.
        wr(3, 32'h11111111);
        drive(1'b1, 1'b1, 3, 3, 3, 32'h22222222);
        exp_q.push_back('{d1: 32'h22222222, d2: 32'h22222222});
        tick();
        // One port bypassing, the other reading stored data.
        drive(1'b1, 1'b1, 4, 7, 4, 32'h44444444);
        exp_q.push_back('{d1: 32'h44444444, d2: 32'hDEADBEEF});
        tick();
        rd(3, 4, 32'h22222222, 32'h44444444);

        // Hold with READ low.
        wr(2, 32'hA5A5A5A5);
        rd(2, 15, 32'hA5A5A5A5, 32'h00000010);
        wr(1, 32'h0);
        check("hold_valid", {31'b0, VALID}, 32'h0);
        check("hold_r1", DATA_R1, 32'hA5A5A5A5);
        check("hold_r2", DATA_R2, 32'h00000010);
        idle();
        tick();
        check("hold_r1_again", DATA_R1, 32'hA5A5A5A5);

        // Streaming reads over regs 0..15, each preloaded with its index.
        for (int i = 0; i < 16; i++) wr(i, 32'(i));
        for (int i = 0; i < 16; i++) begin
            rd(i, 15 - i, 32'(i), 32'(15 - i));
            check("stream_valid", {31'b0, VALID}, 32'h1);
        end
        idle();
        tick();
        check("stream_end_valid", {31'b0, VALID}, 32'h0);

        // Reset in the same cycle as WRITE and READ.
        wr(9, 32'h12345678);
        drive(1'b1, 1'b1, 9, 9, 9, 32'h00000001);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_valid", {31'b0, VALID}, 32'h0);
        check("midrst_r1", DATA_R1, 32'h0);
        check("midrst_r2", DATA_R2, 32'h0);
        idle();
        tick();
        check("post_rst_valid", {31'b0, VALID}, 32'h0);
        rd(9, 7, 32'h0, 32'h0);
        idle();
        tick();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_file_2r1w

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Register file with two read ports and one write port: 32 entries of 32 bits each. It supplies operands to the datapath's selection muxes and to the ALU stage. Reads are registered, with a one-cycle read-valid strobe. Writes commit on the clock edge. Register 0 is optionally hardwired to zero.

Parameters:
DATA_WIDTH, 32, width of each register and of every data port
ADDR_WIDTH, 5, width of each address port
DEPTH, 32, number of registers; must equal 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary storage

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous, active-high reset
READ  input  1  read request, sampled on the rising edge
WRITE  input  1  write request, sampled on the rising edge
ADDR_R1  input  ADDR_WIDTH  read port 1 address
ADDR_R2  input  ADDR_WIDTH  read port 2 address
ADDR_W  input  ADDR_WIDTH  write address
DATA_W  input  DATA_WIDTH  write data
DATA_R1  output  DATA_WIDTH  registered read data, port 1
DATA_R2  output  DATA_WIDTH  registered read data, port 2
VALID  output  1  high for exactly one cycle after each accepted read

Behaviour:
- Clocking and reset (already decided): one clock, CLK. RST is synchronous and active-high.
  - While RST is high at a rising edge: all DEPTH registers, DATA_R1, DATA_R2 and VALID are cleared to 0.
  - READ and WRITE are ignored during that cycle.
- Write:
  - At a rising edge with WRITE=1 and RST=0: mem[ADDR_W] <= DATA_W.
  - If ZERO_REG=1 and ADDR_W=0, the write is dropped silently.
- Read, latency 1:
  - At a rising edge with READ=1 and RST=0: DATA_R1 <= mem[ADDR_R1] and DATA_R2 <= mem[ADDR_R2]. VALID <= 1.
  - With READ=0: VALID <= 0, and DATA_R1/DATA_R2 hold their last values (no glitch, no clear).
- Read-during-write on the same edge:
  - Write-first bypass: a read port whose address equals ADDR_W returns DATA_W, not the old contents.
  - Exception: the bypass is suppressed when ZERO_REG=1 and the address is 0; that port returns 0.
  - Both read ports may bypass in the same cycle.
- Both read addresses equal: both ports return the same value. No conflict.
- Back-to-back reads: READ held high gives VALID high every cycle, and each cycle's data reflects the addresses sampled at the preceding edge.
- Reset mid-operation: a READ or WRITE asserted in the same cycle as RST is discarded. VALID is 0 on the cycle after reset.
- Address range: all 2**ADDR_WIDTH addresses are valid. No out-of-range or wrap handling is needed.
- No combinational path from any input to any output.

Decomposition:
- Shared package rf_pkg:
  - Constants: RF_DATA_WIDTH=32, RF_ADDR_WIDTH=5, RF_DEPTH=32, RF_ZERO_ADDR=0.
  - Typedefs rf_data_t and rf_addr_t.
- One sub-module, rf_read_port:
  - Combinational DEPTH:1 selection, built from the team's 32-bit mux tree, plus the bypass compare against ADDR_W/WRITE.
  - Instantiated twice, once per read port. Output registers stay in the top level.

Test Plan:
- Reset: hold RST=1 for 2 cycles, then READ with ADDR_R1=5, ADDR_R2=31 -> DATA_R1=0, DATA_R2=0, VALID=1 for exactly one cycle.
- Write then read: write 0xDEADBEEF to reg 7 and 0x00000010 to reg 15; READ with ADDR_R1=7, ADDR_R2=15 -> next cycle DATA_R1=0xDEADBEEF, DATA_R2=0x00000010, VALID=1.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0, then read reg 0 on both ports -> 0x00000000. Same-cycle write+read of reg 0 -> also 0.
- Bypass: reg 3 holds 0x11111111; on the same edge WRITE reg 3 with 0x22222222 and READ with ADDR_R1=3, ADDR_R2=3 -> both 0x22222222.
- Hold and VALID: after a read returning 0xA5A5A5A5, drop READ and write reg 1 with 0x0 -> DATA_R1 stays 0xA5A5A5A5, VALID=0. Stream READ for 16 cycles over regs 0-15, each preloaded with its own index -> VALID high for 16 consecutive cycles with DATA_R1=0..15 in order.
- Reset mid-operation: reg 9 holds 0x12345678; assert RST together with WRITE reg 9=0x1 and READ -> all registers 0 and VALID=0 next cycle; a later read of reg 9 returns 0.
